tessia_wb_trace: RTL and testbench

//  Hardware replacement for the bench's negedge $display logging of TessiaX32.

---
 rtl/tessia_trace_pkg.sv | 21 ++
 rtl/tessia_trace_fifo.sv | 72 +++++++
 rtl/tessia_wb_trace.sv | 89 ++++++++
 tb/tb_tessia_wb_trace.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tessia_trace_pkg.sv
// Shared types and widths for the TessiaX32 writeback trace buffer.
package tessia_trace_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } trace_state_e;

   localparam int DEF_STAMP_W = 16;
   localparam int DATA_W      = 37;

   // Payload of one writeback; the cycle stamp is prepended by the top.
   typedef struct packed {
      logic        branch;
      logic [3:0]  a3;
      logic [31:0] wd3;
   } trace_data_t;

endpackage

// File: rtl/tessia_trace_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; rd_data is a registered copy of the head.
module tessia_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 53
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        din,
   input  logic                    pop,
   output logic                    rd_valid,
   output logic [WIDTH-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr, rptr_n;
   logic [AW:0]      cnt_n;
   logic             do_push, do_pop, head_from_din;

   assign full = (count == (AW+1)'(DEPTH));

   // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      do_pop        = pop && (count != '0);
      do_push       = push && (!full || do_pop);
      rptr_n        = do_pop ? rptr + 1'b1 : rptr;
      cnt_n         = count;
      if (do_push && !do_pop)
         cnt_n = count + 1'b1;
      else if (!do_push && do_pop)
         cnt_n = count - 1'b1;
      // A push into an empty (or emptying) FIFO becomes the next head directly.
      head_from_din = do_push && (count == {{AW{1'b0}}, do_pop});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (do_push)
            wptr <= wptr + 1'b1;
         rptr     <= rptr_n;
         count    <= cnt_n;
         rd_valid <= (cnt_n != '0);
         if (head_from_din)
            rd_data <= din;
         else if (cnt_n != '0)
            rd_data <= mem[rptr_n];
      end
   end

   // NOTE: storage is deliberately not reset; count/rd_valid qualify it, and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wptr] <= din;
   end

endmodule

// File: rtl/tessia_wb_trace.sv
// Triggered writeback trace capture for TessiaX32: FSM, cycle stamp, post-trigger counter, overflow.
module tessia_wb_trace
   import tessia_trace_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int POST    = 16,
   parameter int STAMP_W = DEF_STAMP_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        arm,
   input  logic                        trig_any,
   input  logic [3:0]                  trig_reg,
   input  logic                        RegWrite,
   input  logic [3:0]                  A3,
   input  logic [31:0]                 WD3,
   input  logic                        BranchTaken,
   input  logic                        rd_ready,
   output logic                        rd_valid,
   output logic [STAMP_W+DATA_W-1:0]   rd_data,
   output logic [1:0]                  state,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow
);

   localparam int PW = $clog2(POST + 1);

   trace_state_e   st;
   logic [STAMP_W-1:0] stamp;
   logic [PW-1:0]  post_cnt, post_next;
   trace_data_t    wb;
   logic           wev, hit, do_write, pop, full;

   always_comb begin
      wev        = RegWrite && (st == ARMED || st == CAPTURE);
      // In ARMED only the trigger is stored; in CAPTURE every writeback is.
      hit        = wev && (st == CAPTURE || trig_any || A3 == trig_reg);
      do_write   = hit && !arm;
      pop        = rd_valid && rd_ready && !arm;
      post_next  = post_cnt + 1'b1;
      wb.branch  = BranchTaken;
      wb.a3      = A3;
      wb.wd3     = WD3;
   end

   // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st       <= IDLE;
         stamp    <= '0;
         post_cnt <= '0;
         overflow <= 1'b0;
      end else if (arm) begin
         st       <= ARMED;
         stamp    <= '0;
         post_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if ((st == ARMED || st == CAPTURE) && stamp != '1)
            stamp <= stamp + 1'b1;
         if (hit) begin
            // Dropped entries still count, so the session length is fixed by POST alone.
            post_cnt <= post_next;
            st       <= (post_next == PW'(POST)) ? DONE : CAPTURE;
            if (full && !pop)
               overflow <= 1'b1;
         end
      end
   end

   assign state = st;

   tessia_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (STAMP_W + DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .flush    (arm),
      .push     (do_write),
      .din      ({stamp, wb}),
      .pop      (pop),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .full     (full)
   );

endmodule

// File: tb/tb_tessia_wb_trace.sv
// Bench for tessia_wb_trace: three parameterisations checked against a queue-based reference model.
module tb_tessia_wb_trace;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        arm = 1'b0, trig_any = 1'b0, RegWrite = 1'b0, BranchTaken = 1'b0, rd_ready = 1'b0;
   logic [3:0]  trig_reg = '0, A3 = '0;
   logic [31:0] WD3 = '0;
   int          sel = 0;

   logic        arm0, arm1, arm2;
   logic        rv0, rv1, rv2, ov0, ov1, ov2;
   logic [52:0] rd0, rd1, rd2;
   logic [1:0]  st0, st1, st2;
   logic [4:0]  c0, c1;
   logic [2:0]  c2;

   logic        o_valid, o_ovf;
   logic [52:0] o_data;
   logic [1:0]  o_state;
   logic [4:0]  o_count;

   int checks = 0;
   int fails  = 0;

   assign arm0 = arm && (sel == 0);
   assign arm1 = arm && (sel == 1);
   assign arm2 = arm && (sel == 2);

   tessia_wb_trace #(.DEPTH(16), .POST(16), .STAMP_W(16)) u_main (
      .clk(clk), .reset(reset), .arm(arm0), .trig_any(trig_any), .trig_reg(trig_reg),
      .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .BranchTaken(BranchTaken), .rd_ready(rd_ready),
      .rd_valid(rv0), .rd_data(rd0), .state(st0), .count(c0), .overflow(ov0));

   tessia_wb_trace #(.DEPTH(16), .POST(3), .STAMP_W(16)) u_post3 (
      .clk(clk), .reset(reset), .arm(arm1), .trig_any(trig_any), .trig_reg(trig_reg),
      .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .BranchTaken(BranchTaken), .rd_ready(rd_ready),
      .rd_valid(rv1), .rd_data(rd1), .state(st1), .count(c1), .overflow(ov1));

   tessia_wb_trace #(.DEPTH(4), .POST(6), .STAMP_W(16)) u_small (
      .clk(clk), .reset(reset), .arm(arm2), .trig_any(trig_any), .trig_reg(trig_reg),
      .RegWrite(RegWrite), .A3(A3), .WD3(WD3), .BranchTaken(BranchTaken), .rd_ready(rd_ready),
      .rd_valid(rv2), .rd_data(rd2), .state(st2), .count(c2), .overflow(ov2));

   always #5 clk = ~clk;

   always_comb begin
      o_valid = rv0; o_data = rd0; o_state = st0; o_count = c0; o_ovf = ov0;
      if (sel == 1) begin
         o_valid = rv1; o_data = rd1; o_state = st1; o_count = c1; o_ovf = ov1;
      end else if (sel == 2) begin
         o_valid = rv2; o_data = rd2; o_state = st2; o_count = {2'b00, c2}; o_ovf = ov2;
      end
   end

   // Reference model: the trace session described as a bounded queue plus a few integers.
   int          m_depth, m_post, m_state, m_stamp, m_pc;
   logic        m_ovf;
   logic [52:0] m_last;
   logic [52:0] mq[$];

   task automatic model_reset();
      mq.delete();
      m_state = 0; m_stamp = 0; m_pc = 0; m_ovf = 1'b0; m_last = '0;
   endtask

   task automatic model_step(input logic a, input logic rw, input logic [3:0] a3_i,
                             input logic [31:0] d, input logic br, input logic rdy);
      logic        wr;
      logic [52:0] e;
      int          s0;
      if (a) begin
         mq.delete();
         m_state = 1; m_stamp = 0; m_pc = 0; m_ovf = 1'b0;
         return;
      end
      s0 = m_state;
      e  = {16'(m_stamp), br, a3_i, d};
      wr = rw && ((s0 == 1 && (trig_any || a3_i == trig_reg)) || s0 == 2);
      if (wr) begin
         m_pc++;
         m_state = (m_pc >= m_post) ? 3 : 2;
      end
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (wr) begin
         if (mq.size() < m_depth) mq.push_back(e);
         else m_ovf = 1'b1;
      end
      if ((s0 == 1 || s0 == 2) && m_stamp < 65535) m_stamp++;
      if (mq.size() > 0) m_last = mq[0];
   endtask

   task automatic cycle(input logic a, input logic rw, input logic [3:0] a3_i,
                        input logic [31:0] d, input logic br, input logic rdy);
      arm = a; RegWrite = rw; A3 = a3_i; WD3 = d; BranchTaken = br; rd_ready = rdy;
      model_step(a, rw, a3_i, d, br, rdy);
      @(posedge clk);
      #1;
      arm = 1'b0; RegWrite = 1'b0; rd_ready = 1'b0;
   endtask

   task automatic do_reset(input int s, input int dep, input int pst);
      sel = s; m_depth = dep; m_post = pst;
      arm = 1'b0; RegWrite = 1'b0; rd_ready = 1'b0;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset(0, 16, 16);
      checks++;
      if (o_state !== 2'd0 || o_count !== 5'd0 || o_valid !== 1'b0 || o_data !== 53'd0 || o_ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_init: state=%0d count=%0d valid=%0b data=%h ovf=%0b, want all zero",
                  o_state, o_count, o_valid, o_data, o_ovf);
      end
      trig_any = 1'b1;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 4'(k + 1), $urandom, 1'b0, 1'b0);
      checks++;
      if (o_count !== 5'd3 || o_state !== 2'd2) begin
         fails++;
         $display("FAIL reset_precap: count=%0d state=%0d, want 3 and 2", o_count, o_state);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (o_state !== 2'd0 || o_count !== 5'd0 || o_valid !== 1'b0 || o_data !== 53'd0 || o_ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: state=%0d count=%0d valid=%0b data=%h ovf=%0b, want all zero",
                  o_state, o_count, o_valid, o_data, o_ovf);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (o_valid !== 1'b0 || o_count !== 5'd0 || o_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_release: valid=%0b count=%0d state=%0d, want 0 0 0", o_valid, o_count, o_state);
         end
      end
   endtask

   task automatic test_reg_trigger();
      logic [52:0] e1, e2;
      do_reset(0, 16, 16);
      trig_any = 1'b0; trig_reg = 4'd5;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'd2, $urandom, 1'b0, 1'b0);
      checks++;
      if (o_count !== 5'd0 || o_state !== 2'd1) begin
         fails++;
         $display("FAIL regtrig_r2: count=%0d state=%0d, want 0 and 1", o_count, o_state);
      end
      cycle(1'b0, 1'b1, 4'd5, 32'h2A, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'd7, 32'h10, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      checks++;
      if (o_count !== 5'd2 || o_state !== 2'd2 || o_data !== m_last) begin
         fails++;
         $display("FAIL regtrig_count: count=%0d state=%0d data=%h, want 2 2 %h", o_count, o_state, o_data, m_last);
      end
      e1 = o_data;
      cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
      e2 = o_data;
      checks++;
      if (e1[36:0] !== {1'b1, 4'd5, 32'h2A}) begin
         fails++;
         $display("FAIL regtrig_e1: got %h want br=1 r5 0x2A", e1[36:0]);
      end
      checks++;
      if (e2[35:0] !== {4'd7, 32'h10}) begin
         fails++;
         $display("FAIL regtrig_e2: got %h want r7 0x10", e2[35:0]);
      end
      checks++;
      if (e2[52:37] <= e1[52:37]) begin
         fails++;
         $display("FAIL regtrig_stamp: got %0d then %0d, want strictly increasing", e1[52:37], e2[52:37]);
      end
   endtask

   task automatic test_post3();
      do_reset(1, 16, 3);
      trig_any = 1'b1;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         checks++;
         if (o_state !== ((k < 2) ? 2'd2 : 2'd3) || o_count !== ((k < 2) ? 5'(k + 1) : 5'd3)) begin
            fails++;
            $display("FAIL post3_w%0d: state=%0d count=%0d", k, o_state, o_count);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] dv[6];
      logic        bv[6];
      do_reset(2, 4, 6);
      trig_any = 1'b1;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         dv[k] = $urandom;
         bv[k] = 1'($urandom_range(0, 1));
         cycle(1'b0, 1'b1, 4'(k), dv[k], bv[k], 1'b0);
      end
      checks++;
      if (o_count !== 5'd4 || o_ovf !== 1'b1 || o_state !== 2'd3) begin
         fails++;
         $display("FAIL ovf_final: count=%0d ovf=%0b state=%0d, want 4 1 3", o_count, o_ovf, o_state);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_valid !== 1'b1 || o_data !== {16'(k), bv[k], 4'(k), dv[k]}) begin
            fails++;
            $display("FAIL ovf_drain%0d: valid=%0b data=%h want %h", k, o_valid, o_data, {16'(k), bv[k], 4'(k), dv[k]});
         end
         cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
      end
      checks++;
      if (o_valid !== 1'b0 || o_count !== 5'd0) begin
         fails++;
         $display("FAIL ovf_empty: valid=%0b count=%0d, want 0 0", o_valid, o_count);
      end
   endtask

   task automatic test_full_rw();
      do_reset(2, 4, 6);
      trig_any = 1'b1;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 4'(k), $urandom, 1'b0, 1'b0);
      checks++;
      if (o_count !== 5'd4 || o_state !== 2'd2 || o_ovf !== 1'b0) begin
         fails++;
         $display("FAIL full_pre: count=%0d state=%0d ovf=%0b, want 4 2 0", o_count, o_state, o_ovf);
      end
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b1, 4'(k + 4), $urandom, 1'b0, 1'b1);
         checks++;
         if (o_count !== 5'd4 || o_ovf !== 1'b0 || o_data[52:37] !== 16'(k + 1)) begin
            fails++;
            $display("FAIL full_rw%0d: count=%0d ovf=%0b head_stamp=%0d, want 4 0 %0d",
                     k, o_count, o_ovf, o_data[52:37], k + 1);
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (o_data !== m_last || o_data[52:37] !== 16'(k + 2)) begin
            fails++;
            $display("FAIL full_drain%0d: data=%h want %h stamp %0d", k, o_data, m_last, k + 2);
         end
         cycle(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_arm_capture();
      do_reset(0, 16, 16);
      trig_any = 1'b1;
      cycle(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'd1, $urandom, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'd2, $urandom, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 4'd3, $urandom, 1'b0, 1'b1);
      checks++;
      if (o_count !== 5'd0 || o_valid !== 1'b0 || o_state !== 2'd1) begin
         fails++;
         $display("FAIL rearm: count=%0d valid=%0b state=%0d, want 0 0 1", o_count, o_valid, o_state);
      end
      cycle(1'b0, 1'b1, 4'd9, $urandom, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data[52:37] !== 16'd0 || o_data[35:32] !== 4'd9) begin
         fails++;
         $display("FAIL rearm_stamp: valid=%0b stamp=%0d a3=%0d, want 1 0 9", o_valid, o_data[52:37], o_data[35:32]);
      end
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++) begin
         do_reset(s, (s == 2) ? 4 : 16, (s == 0) ? 16 : ((s == 1) ? 3 : 6));
         trig_any = 1'($urandom_range(0, 1));
         trig_reg = 4'($urandom_range(0, 15));
         for (int i = 0; i < 200; i++) begin
            logic a, rdy;
            a   = (i == 0) || ($urandom_range(0, 29) == 0);
            rdy = (s == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), rdy);
            checks++;
            if (o_state !== 2'(m_state) || o_count !== 5'(mq.size()) || o_valid !== (mq.size() != 0) ||
                o_data !== m_last || o_ovf !== m_ovf) begin
               fails++;
               $display("FAIL rand s%0d i%0d: state=%0d/%0d count=%0d/%0d valid=%0b data=%h/%h ovf=%0b/%0b",
                        s, i, o_state, m_state, o_count, mq.size(), o_valid, o_data, m_last, o_ovf, m_ovf);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_reg_trigger();
      test_post3();
      test_overflow();
      test_full_rw();
      test_arm_capture();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
